// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and defaults for the memory arbiter
package riscv_pkg;

    localparam int DEFAULT_NUM_CORES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner selection
//
// Ports:
//   req        per-core request vector
//   last_grant index of the most recently served core
//   valid      at least one request is pending
//   grant      index of the winner, searching upward from last_grant+1
module rr_picker #(
    parameter int NUM_CORES = 4,
    parameter int IW        = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req,
    input  logic [IW-1:0]        last_grant,
    output logic                 valid,
    output logic [IW-1:0]        grant
);

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester
    // after last_grant is the final assignment and therefore wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int i = NUM_CORES; i >= 1; i--) begin
            idx = IW'((int'(last_grant) + i) % NUM_CORES);
            if (req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of N cores onto one memory port
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   core_req/we/addr/wdata        per-core command, held until core_ready
//   core_ready, core_err          one-hot completion pulse, timeout flag
//   core_rdata                    load data, valid with core_ready
//   mem_req/we/addr/wdata         memory command, held until mem_ack
//   mem_ack, mem_rdata            memory completion and load data
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_CORES      = DEFAULT_NUM_CORES,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CORES-1:0]       core_req,
    input  logic [NUM_CORES-1:0]       core_we,
    input  logic [NUM_CORES-1:0][31:0] core_addr,
    input  logic [NUM_CORES-1:0][31:0] core_wdata,
    output logic [NUM_CORES-1:0]       core_ready,
    output logic                       core_err,
    output logic [31:0]                core_rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    input  logic                       mem_ack,
    input  logic [31:0]                mem_rdata
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    arb_state_t    state_q;
    arb_state_t    state_d;

    logic [IW-1:0] grant_q;
    logic [IW-1:0] last_grant_q;
    logic          we_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;

    logic          pick_valid;
    logic [IW-1:0] pick_grant;

    rr_picker #(
        .NUM_CORES (NUM_CORES),
        .IW        (IW)
    ) u_picker (
        .req        (core_req),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (pick_valid) state_d = WAIT;
            WAIT: if (mem_ack || cnt_q == CNT_LIMIT) state_d = RESP;
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All outputs are decoded from the registered state, so an async reset
    // of state_q forces every output low without waiting for a clock.
    always_comb begin
        core_ready = '0;
        core_err   = 1'b0;
        core_rdata = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            WAIT: begin
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                core_ready = NUM_CORES'(1) << grant_q;
                core_err   = err_q;
                core_rdata = rdata_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_CORES - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_q <= pick_grant;
                        we_q    <= core_we[pick_grant];
                        addr_q  <= core_addr[pick_grant];
                        wdata_q <= core_wdata[pick_grant];
                        rdata_q <= '0;
                        err_q   <= 1'b0;
                        cnt_q   <= '0;
                    end
                end
                WAIT: begin
                    // An ack on the limit cycle takes priority over the abort.
                    if (mem_ack) begin
                        rdata_q <= we_q ? 32'h0 : mem_rdata;
                    end else if (cnt_q == CNT_LIMIT) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    last_grant_q <= grant_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic             clk;
    logic             rst;
    logic [3:0]       core_req;
    logic [3:0]       core_we;
    logic [3:0][31:0] core_addr;
    logic [3:0][31:0] core_wdata;
    logic [3:0]       core_ready;
    logic             core_err;
    logic [31:0]      core_rdata;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    int checks;
    int errors;

    mem_arbiter #(
        .NUM_CORES      (4),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ready (core_ready),
        .core_err   (core_err),
        .core_rdata (core_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_default_cmds();
        for (int i = 0; i < 4; i++) begin
            core_addr[i]  = 32'h1000 + 32'(i * 4);
            core_wdata[i] = 32'hB000_0000 + 32'(i);
        end
        core_we = 4'b0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (core_ready !== 4'b0 || core_err !== 1'b0 || core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_core_outputs ready=%b err=%b rdata=%h required 0", core_ready, core_err, core_rdata);
        end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_outputs req=%b we=%b addr=%h wdata=%h required 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_all_request();
        int c;
        core_req  = 4'b1111;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA000_0000;
        for (int k = 0; k < 5; k++) begin
            c = k % 4;
            tick();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h1000 + 32'(c * 4) || core_ready !== 4'b0) begin
                errors++;
                $display("FAIL all_req_wait_%0d req=%b addr=%h ready=%b required 1 %h 0000", k, mem_req, mem_addr, core_ready, 32'h1000 + 32'(c * 4));
            end
            mem_rdata = 32'hA000_0000 + 32'(k);
            tick();
            checks++;
            if (core_ready !== 4'(1 << c) || core_rdata !== 32'hA000_0000 + 32'(k) || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL all_req_resp_%0d ready=%b rdata=%h mem_req=%b required %b %h 0", k, core_ready, core_rdata, mem_req, 4'(1 << c), 32'hA000_0000 + 32'(k));
            end
            if (k == 4) begin
                core_req = 4'b0000;
                mem_ack  = 1'b0;
            end
            tick();
            checks++;
            if (core_ready !== 4'b0 || mem_req !== 1'b0) begin
                errors++;
                $display("FAIL all_req_idle_%0d ready=%b mem_req=%b required 0000 0", k, core_ready, mem_req);
            end
        end
    endtask

    task automatic test_single_load();
        core_req     = 4'b0100;
        core_addr[2] = 32'h100;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL load_wait req=%b addr=%h we=%b required 1 00000100 0", mem_req, mem_addr, mem_we);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if (core_ready !== 4'b0100 || core_rdata !== 32'hDEAD_BEEF || core_err !== 1'b0) begin
            errors++;
            $display("FAIL load_resp ready=%b rdata=%h err=%b required 0100 deadbeef 0", core_ready, core_rdata, core_err);
        end
        core_req = 4'b0000;
        mem_ack  = 1'b0;
        tick();
        set_default_cmds();
    endtask

    task automatic test_reset_mid_wait();
        core_req = 4'b0010;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1004) begin
            errors++;
            $display("FAIL rst_pre_wait req=%b addr=%h required 1 00001004", mem_req, mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || core_ready !== 4'b0) begin
            errors++;
            $display("FAIL rst_async mem_req=%b ready=%b required 0 0000", mem_req, core_ready);
        end
        tick();
        rst      = 1'b0;
        core_req = 4'b1111;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1000 || core_ready !== 4'b0) begin
            errors++;
            $display("FAIL rst_next_grant req=%b addr=%h ready=%b required 1 00001000 0000", mem_req, mem_addr, core_ready);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_0000;
        tick();
        checks++;
        if (core_ready !== 4'b0001) begin
            errors++;
            $display("FAIL rst_next_ready ready=%b required 0001", core_ready);
        end
        core_req = 4'b0000;
        mem_ack  = 1'b0;
        tick();
    endtask

    task automatic test_store();
        core_req      = 4'b0010;
        core_we       = 4'b0010;
        core_addr[1]  = 32'h20;
        core_wdata[1] = 32'hCAFE_F00D;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL store_wait req=%b we=%b addr=%h wdata=%h required 1 1 00000020 cafef00d", mem_req, mem_we, mem_addr, mem_wdata);
        end
        core_wdata[1] = 32'h0;
        core_addr[1]  = 32'h44;
        core_req      = 4'b1010;
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL store_hold req=%b addr=%h wdata=%h required 1 00000020 cafef00d", mem_req, mem_addr, mem_wdata);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        checks++;
        if (core_ready !== 4'b0010 || core_rdata !== 32'h0 || core_err !== 1'b0) begin
            errors++;
            $display("FAIL store_resp ready=%b rdata=%h err=%b required 0010 00000000 0", core_ready, core_rdata, core_err);
        end
        core_req = 4'b0000;
        mem_ack  = 1'b0;
        tick();
        set_default_cmds();
    endtask

    task automatic test_timeout();
        int cycles;
        core_req     = 4'b0001;
        core_addr[0] = 32'h40;
        mem_rdata    = 32'hFFFF_FFFF;
        tick();
        cycles = 0;
        for (int i = 0; i < 10 && mem_req === 1'b1; i++) begin
            cycles++;
            tick();
        end
        checks++;
        if (cycles !== 4) begin
            errors++;
            $display("FAIL timeout_len mem_req cycles=%0d required 4", cycles);
        end
        checks++;
        if (core_ready !== 4'b0001 || core_err !== 1'b1 || core_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_resp ready=%b err=%b rdata=%h required 0001 1 00000000", core_ready, core_err, core_rdata);
        end
        core_req = 4'b0000;
        tick();
        checks++;
        if (core_err !== 1'b0 || core_ready !== 4'b0) begin
            errors++;
            $display("FAIL timeout_idle err=%b ready=%b required 0 0000", core_err, core_ready);
        end
        set_default_cmds();
    endtask

    task automatic test_race();
        core_req = 4'b1000;
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100C) begin
            errors++;
            $display("FAIL race_wait4 req=%b addr=%h required 1 0000100c", mem_req, mem_addr);
        end
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A_A5A5;
        tick();
        checks++;
        if (core_ready !== 4'b1000 || core_err !== 1'b0 || core_rdata !== 32'h5A5A_A5A5) begin
            errors++;
            $display("FAIL race_resp ready=%b err=%b rdata=%h required 1000 0 5a5aa5a5", core_ready, core_err, core_rdata);
        end
        core_req = 4'b0000;
        mem_ack  = 1'b0;
        tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        core_req  = 4'b0000;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        set_default_cmds();

        test_reset();
        test_all_request();
        test_single_load();
        test_reset_mid_wait();
        test_store();
        test_timeout();
        test_race();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
